mux_arb_n: RTL

Parametrised N-input, WIDTH-bit selector with a registered output stage, valid/ready handshakes on every lane and on the output, and two grant modes: explicit (lane chosen by `ctrl`) and round-robin (fair scan of requesting lanes). It is the next-generation datapath selector for the multicycle core. Uses include shared-bus sources competing for one register-file or memory port. Unlike the plain 8:1 select, an out-of-range `ctrl` does not fall back to lane 0: nothing is granted and an error is flagged.

---
 rtl/mux_arb_n_pkg.sv | 7 +
 rtl/mux_arb_n_rr_pick.sv | 34 +++
 rtl/mux_arb_n.sv | 83 ++++++++
 3 files changed

// File: rtl/mux_arb_n_pkg.sv
// rtl/mux_arb_n_pkg.sv - shared constants for the mux_arb_n selector
package mux_arb_n_pkg;

  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_RR       = 1'b1;

endpackage

// File: rtl/mux_arb_n_rr_pick.sv
// rtl/mux_arb_n_rr_pick.sv - combinational round-robin picker, search starts at base+1
module rr_pick #(
  parameter int N_IN  = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  req,
  input  logic [SEL_W-1:0] base,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [2*N_IN-1:0] dbl;
  logic [N_IN-1:0]   rot;
  logic [SEL_W:0]    start;
  logic [SEL_W:0]    off;
  logic [SEL_W:0]    pos;

  always_comb begin
    start = {1'b0, base} + 1'b1;
    if (start >= (SEL_W+1)'(N_IN)) start = '0;
    // Rotating a doubled copy puts the start lane at bit 0.
    dbl = {req, req};
    rot = N_IN'(dbl >> start);
    off = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (rot[i]) off = (SEL_W+1)'(i);
    end
    pos = start + off;
    if (pos >= (SEL_W+1)'(N_IN)) pos = pos - (SEL_W+1)'(N_IN);
    gnt_idx = pos[SEL_W-1:0];
    gnt_any = |req;
  end

endmodule

// File: rtl/mux_arb_n.sv
// rtl/mux_arb_n.sv - N-lane valid/ready selector with explicit and round-robin grant
module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N_IN  = 8,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      ctrl,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sel_err
);

  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_any;
  logic [SEL_W-1:0] gnt_idx;
  logic             grant;
  logic             exp_any;
  logic             ctrl_ok;
  logic             load_ok;
  logic             xfer;
  logic [WIDTH-1:0] lane_data;

  rr_pick #(.N_IN(N_IN), .SEL_W(SEL_W)) u_rr_pick (
    .req     (in_valid),
    .base    (last_grant),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  assign load_ok = !out_valid || out_ready;
  assign ctrl_ok = int'(ctrl) < N_IN;

  always_comb begin
    exp_any = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (int'(ctrl) == i && in_valid[i]) exp_any = 1'b1;
    end
    gnt_idx = (mode == MODE_RR) ? rr_idx : ctrl;
    grant   = (mode == MODE_RR) ? rr_any : exp_any;
    xfer    = grant && load_ok;
    lane_data = '0;
    in_ready  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (gnt_idx == SEL_W'(i)) begin
        lane_data   = in_data[i*WIDTH +: WIDTH];
        // Async reset must also withdraw acceptance while it is held.
        in_ready[i] = xfer && !reset;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data   <= '0;
      out_sel    <= '0;
      out_valid  <= 1'b0;
      sel_err    <= 1'b0;
      last_grant <= SEL_W'(N_IN - 1);
    end else begin
      sel_err <= (mode == MODE_EXPLICIT) && !ctrl_ok;
      if (xfer) begin
        out_data   <= lane_data;
        out_sel    <= gnt_idx;
        out_valid  <= 1'b1;
        last_grant <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
